// File: rtl/systolic_conv_ctrl.sv
// Frame sequencer for the 2D systolic convolution array: raster fetch, drain, done handshake.
// Optional window counter output win_cnt is compiled in with `define SYSCTRL_WIN_CNT_EN.
module systolic_conv_ctrl #(
  parameter int unsigned IMG_WIDTH   = 3,
  parameter int unsigned IMG_HEIGHT  = 6,
  parameter int unsigned KERNEL_SIZE = 2,
  parameter int unsigned PIPE_LAT    = 4,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              px_valid,
  output logic              window_valid,
  output logic              busy,
  output logic              done
`ifdef SYSCTRL_WIN_CNT_EN
  ,
  output logic [15:0]       win_cnt
`endif
);

  localparam int unsigned COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned ROW_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned DRN_W     = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam int unsigned LAST_ADDR = IMG_WIDTH * IMG_HEIGHT - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [ROW_W-1:0]  row, row_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DRN_W-1:0]  drain_cnt, drain_nxt;
  logic              rd_en_c;
  logic              win_c;
  logic              accept_c;

  // State and fetch/drain counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      mem_addr  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      mem_addr  <= addr_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Next-state, counter advance and fetch decode
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    addr_nxt  = mem_addr;
    drain_nxt = drain_cnt;
    rd_en_c   = 1'b0;
    win_c     = 1'b0;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          col_nxt   = '0;
          row_nxt   = '0;
          addr_nxt  = '0;
          accept_c  = 1'b1;
        end
      end
      FETCH: begin
        if (!hold) begin
          rd_en_c = 1'b1;
          win_c   = (col >= COL_W'(KERNEL_SIZE - 1)) && (row >= ROW_W'(KERNEL_SIZE - 1));
          if (mem_addr == ADDR_W'(LAST_ADDR)) begin
            // last pixel: counters stay put so none runs past its terminal value
            state_nxt = DRAIN;
            drain_nxt = '0;
          end else begin
            addr_nxt = mem_addr + ADDR_W'(1);
            if (col == COL_W'(IMG_WIDTH - 1)) begin
              col_nxt = '0;
              row_nxt = row + ROW_W'(1);
            end else begin
              col_nxt = col + COL_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRN_W'(PIPE_LAT)) begin
          state_nxt = DONE;
        end else begin
          drain_nxt = drain_cnt + DRN_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign mem_rd_en = rd_en_c;

  // Pixel/window flags track the 1-cycle buffer read; busy/done follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      px_valid     <= 1'b0;
      window_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      px_valid     <= rd_en_c;
      window_valid <= win_c;
      busy         <= (state_nxt != IDLE);
      done         <= (state_nxt == DONE);
    end
  end

`ifdef SYSCTRL_WIN_CNT_EN
  // Windows delivered in the current (or most recent) frame
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (accept_c) begin
      win_cnt <= '0;
    end else if (window_valid) begin
      win_cnt <= win_cnt + 16'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept_c;
`endif

endmodule

// File: tb/tb_systolic_conv_ctrl.sv
// Self-checking bench for systolic_conv_ctrl: per-frame expected schedule derived from the hold pattern.
module tb_systolic_conv_ctrl;

  localparam int unsigned W    = 3;
  localparam int unsigned H    = 6;
  localparam int unsigned K    = 2;
  localparam int unsigned P    = 4;
  localparam int unsigned AW   = 8;
  localparam int unsigned N    = W * H;
  localparam int unsigned NWIN = (W - K + 1) * (H - K + 1);
  localparam int unsigned MAXC = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          px_valid;
  logic          window_valid;
  logic          busy;
  logic          done;
`ifdef SYSCTRL_WIN_CNT_EN
  logic [15:0]   win_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_total = 0;

  systolic_conv_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .KERNEL_SIZE(K),
    .PIPE_LAT   (P),
    .ADDR_W     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hold        (hold),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .px_valid    (px_valid),
    .window_valid(window_valid),
    .busy        (busy),
    .done        (done)
`ifdef SYSCTRL_WIN_CNT_EN
    ,
    .win_cnt     (win_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle's inputs shortly after the edge, then sample settled outputs
  task automatic step(input logic h, input logic s, input logic r);
    @(posedge clk);
    #1;
    hold  = h;
    start = s;
    rst   = r;
    #1;
    cyc++;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd"},   32'(mem_rd_en),    32'd0);
    check({tag, "_pv"},   32'(px_valid),     32'd0);
    check({tag, "_wv"},   32'(window_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy),         32'd0);
    check({tag, "_done"}, 32'(done),         32'd0);
`ifdef SYSCTRL_WIN_CNT_EN
    check({tag, "_wcnt"}, 32'(win_cnt), 32'(last_total));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check_quiet("idle");
    end
  endtask

  // hmode: 0 no hold, 1 hold on cycles 3,4,10, 2 random hold
  // smode: 0 start low during frame, 1 random start pulses, 2 start held high
  task automatic run_frame(input int hmode, input int smode);
    logic hv [MAXC];
    logic erd [MAXC];
    int   ea [MAXC];
    int   p;
    int   c;
    int   last;
    int   dc;
    int   ewins;
    int   owins;
    int   npx;
    logic ewv;
    logic s;
    for (int i = 0; i < int'(MAXC); i++) begin
      hv[i]  = 1'b0;
      erd[i] = 1'b0;
      ea[i]  = 0;
    end
    for (int i = 1; i < 150; i++) begin
      case (hmode)
        1:       hv[i] = (i == 3) || (i == 4) || (i == 10);
        2:       hv[i] = ($urandom_range(0, 3) == 0);
        default: hv[i] = 1'b0;
      endcase
    end
    // Pixels issue in raster order on every non-held cycle; done lands PIPE_LAT+2 after the last
    p = 0;
    c = 1;
    last = 0;
    while (p < int'(N)) begin
      if (!hv[c]) begin
        erd[c] = 1'b1;
        ea[c]  = p;
        p++;
        last = c;
      end
      c++;
    end
    dc = last + int'(P) + 2;

    step(1'b0, 1'b1, 1'b0);
    check_quiet("accept");
    ewins = 0;
    owins = 0;
    npx   = 0;
    for (int cc = 1; cc <= dc; cc++) begin
      s = (smode == 2) ? 1'b1 : (smode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(hv[cc], s, 1'b0);
      check("rd", 32'(mem_rd_en), 32'(erd[cc]));
      if (erd[cc]) check("addr", 32'(mem_addr), 32'(ea[cc]));
      check("pv", 32'(px_valid), 32'(erd[cc-1]));
      ewv = erd[cc-1] && ((ea[cc-1] % int'(W)) >= int'(K) - 1) && ((ea[cc-1] / int'(W)) >= int'(K) - 1);
      check("wv", 32'(window_valid), 32'(ewv));
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(cc == dc));
`ifdef SYSCTRL_WIN_CNT_EN
      check("wcnt", 32'(win_cnt), 32'(ewins));
`endif
      if (ewv) ewins++;
      if (window_valid) owins++;
      if (px_valid) npx++;
    end
    check("win_total", 32'(owins), 32'(NWIN));
    check("px_total", 32'(npx), 32'(N));
    last_total = int'(NWIN);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_quiet("reset");
    check("reset_addr", 32'(mem_addr), 32'd0);
    idle(2);

    run_frame(0, 0);
    idle(2);
    run_frame(1, 1);
    idle(1);
    run_frame(0, 2);
    run_frame(0, 2);
    idle(1);

    // Reset in the middle of a fetch aborts the frame with no done
    step(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, 1'b0, 1'b0);
      check("pre_rst_addr", 32'(mem_addr), 32'(c - 1));
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    last_total = 0;
    check_quiet("midrst");
    check("midrst_addr", 32'(mem_addr), 32'd0);
    idle(3);
    run_frame(0, 0);
    idle(1);

    for (int f = 0; f < 8; f++) begin
      run_frame(2, 1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_conv_ctrl.md
Name: systolic_conv_ctrl

Overview:
Frame-level sequencer for the 2D systolic convolution datapath. On a start pulse it streams one IMG_WIDTH x IMG_HEIGHT image out of the pixel buffer in raster order and drives pixel-valid and window-valid into the array. It then drains the array pipeline and reports done. It sits between the pixel buffer and the systolic datapath/valid FSM and owns the busy/done handshake to the host.

Parameters:
IMG_WIDTH, 3, image columns (>= KERNEL_SIZE)
IMG_HEIGHT, 6, image rows (>= KERNEL_SIZE)
KERNEL_SIZE, 2, square kernel edge
PIPE_LAT, 4, datapath latency in cycles to flush after the last pixel
ADDR_W, 8, buffer address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin frame; sampled only in IDLE
hold  in  1  buffer not available this cycle; pauses fetch
mem_rd_en  out  1  buffer read strobe
mem_addr  out  ADDR_W  buffer read address, row*IMG_WIDTH+col
px_valid  out  1  pixel on buffer data bus is valid for the array (mem_rd_en delayed 1 cycle)
window_valid  out  1  current pixel completes a full KxK window
busy  out  1  high in FETCH, DRAIN and DONE
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; col=row=0; mem_addr=0; drain_cnt=0. All outputs are 0 after that edge. Reset mid-frame aborts immediately, with no done pulse. Pipeline flags px_valid and window_valid clear in the same edge.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 -> FETCH, with col=row=0 and mem_addr=0. start=0 -> stay.
- FETCH:
  - mem_rd_en = (state==FETCH) && !hold. This is a combinational decode.
  - mem_rd_en=1: advance col. At col==IMG_WIDTH-1, col wraps to 0 and row increments. mem_addr increments by 1.
  - At the pixel with addr == IMG_WIDTH*IMG_HEIGHT-1, the fetch goes to DRAIN instead of advancing. drain_cnt is set to 0.
  - hold=1: mem_rd_en=0. col, row and addr are frozen and the state is held. The resulting bubbles propagate as px_valid=0.
- px_valid (registered) = mem_rd_en of the previous cycle. This models 1-cycle buffer read latency.
- window_valid (registered) = mem_rd_en && col>=KERNEL_SIZE-1 && row>=KERNEL_SIZE-1, using the col/row of the issued address. It is therefore cycle-aligned with px_valid and never high when px_valid=0.
- Exactly (IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1) window_valid pulses occur per frame, regardless of hold pattern.
- DRAIN:
  - drain_cnt increments every cycle; hold is ignored.
  - When drain_cnt==PIPE_LAT, go to DONE. DRAIN therefore lasts PIPE_LAT+1 cycles, which covers the final px_valid plus the datapath latency.
- DONE: done=1 for exactly this one cycle, then IDLE unconditionally.
- start outside IDLE is ignored; it is not queued. start held high continuously gives back-to-back frames with one IDLE cycle between them.
- Latency with hold=0 throughout:
  - start sampled at edge 0 -> mem_rd_en high cycles 1..W*H.
  - DRAIN occupies cycles W*H+1..W*H+PIPE_LAT+1.
  - done is high at cycle W*H+PIPE_LAT+2. For the defaults that is cycle 24.
- Widths:
  - col uses clog2(IMG_WIDTH) bits and row uses clog2(IMG_HEIGHT) bits, each at least 1.
  - drain_cnt uses clog2(PIPE_LAT+1) bits, at least 1.
  - No counter may wrap past its terminal value.
- Degenerate IMG_WIDTH==KERNEL_SIZE: one window per row, asserted on the last column.

Optional Feature:
SYSCTRL_WIN_CNT_EN.
- Defined: adds output port win_cnt [15:0], reset to 0.
  - Cleared on the start-accept edge, incremented on each window_valid.
  - Holds its final value after done until the next accepted start.
  - Equals the expected window total at done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults (3,6,2,4), rst then start pulse, hold=0:
  - mem_addr 0..17 on cycles 1..18; px_valid on cycles 2..19.
  - Exactly 10 window_valid pulses, at addresses 4,5,7,8,10,11,13,14,16,17.
  - done=1 only at cycle 24; busy high cycles 1..24.
- Same frame with hold=1 on cycles 3,4,10: no address skipped or repeated; px_valid bubbles at cycles 4,5,11; still 10 window_valid; done at cycle 27.
- start pulsed during FETCH and DRAIN: ignored, with no second frame. start held high: second frame's mem_rd_en resumes at cycle 26 (IDLE at 25).
- rst asserted at cycle 9 mid-FETCH: all outputs 0 from the next edge and no done pulse. A new start then produces a complete 18-address frame.
- IMG_WIDTH=4, IMG_HEIGHT=4, KERNEL_SIZE=3, PIPE_LAT=2: 4 window_valid at addresses 10,11,14,15; done at cycle 20.
- SYSCTRL_WIN_CNT_EN defined, default frame: win_cnt reaches 10 at done, holds 10, and clears to 0 on the next accepted start.
